// File: rtl/udp_v2_cfg_arbiter.sv
// Round-robin arbiter that lets two internal requesters share the UDP_v2 AXI4-Lite
// slave register port, one single-word transaction at a time.
module udp_v2_cfg_arbiter #(
    parameter int ADDR_WIDTH    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,

    input  logic                     req0_valid,
    input  logic                     req0_write,
    input  logic [ADDR_WIDTH-1:0]    req0_addr,
    input  logic [31:0]              req0_wdata,
    input  logic [3:0]               req0_wstrb,
    output logic                     req0_ready,
    output logic                     req0_done,
    output logic [31:0]              req0_rdata,
    output logic [1:0]               req0_resp,

    input  logic                     req1_valid,
    input  logic                     req1_write,
    input  logic [ADDR_WIDTH-1:0]    req1_addr,
    input  logic [31:0]              req1_wdata,
    input  logic [3:0]               req1_wstrb,
    output logic                     req1_ready,
    output logic                     req1_done,
    output logic [31:0]              req1_rdata,
    output logic [1:0]               req1_resp,

    output logic [ADDR_WIDTH-1:0]    M_AXI_AWADDR,
    output logic [2:0]               M_AXI_AWPROT,
    output logic                     M_AXI_AWVALID,
    input  logic                     M_AXI_AWREADY,
    output logic [31:0]              M_AXI_WDATA,
    output logic [3:0]               M_AXI_WSTRB,
    output logic                     M_AXI_WVALID,
    input  logic                     M_AXI_WREADY,
    input  logic [1:0]               M_AXI_BRESP,
    input  logic                     M_AXI_BVALID,
    output logic                     M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]    M_AXI_ARADDR,
    output logic [2:0]               M_AXI_ARPROT,
    output logic                     M_AXI_ARVALID,
    input  logic                     M_AXI_ARREADY,
    input  logic [31:0]              M_AXI_RDATA,
    input  logic [1:0]               M_AXI_RRESP,
    input  logic                     M_AXI_RVALID,
    output logic                     M_AXI_RREADY,

    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R
    } state_e;

    localparam logic [ADDR_WIDTH-1:0]    ALIGN_MASK = ~(ADDR_WIDTH'(3));
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = {ERR_CNT_WIDTH{1'b1}};

    state_e                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic                     owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic                     aw_pend_q, aw_pend_d;
    logic                     w_pend_q, w_pend_d;
    logic                     done0_q, done0_d;
    logic                     done1_q, done1_d;
    logic [31:0]              rdata0_q, rdata0_d;
    logic [31:0]              rdata1_q, rdata1_d;
    logic [1:0]               resp0_q, resp0_d;
    logic [1:0]               resp1_q, resp1_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic                     grant0;
    logic                     grant1;
    logic                     sel_write;
    logic                     cpl;
    logic [1:0]               cpl_resp;
    logic [31:0]              cpl_data;

    // On a tie the requester that did not win last time gets the port.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;

    assign M_AXI_AWADDR  = addr_q & ALIGN_MASK;
    assign M_AXI_ARADDR  = addr_q & ALIGN_MASK;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = (state_q == WR_AW_W) && aw_pend_q;
    assign M_AXI_WVALID  = (state_q == WR_AW_W) && w_pend_q;
    assign M_AXI_BREADY  = (state_q == WR_B);
    assign M_AXI_ARVALID = (state_q == RD_AR);
    assign M_AXI_RREADY  = (state_q == RD_R);

    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_resp  = resp0_q;
    assign req1_resp  = resp1_q;
    assign err_count  = err_cnt_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            resp0_q      <= '0;
            resp1_q      <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            resp0_q      <= resp0_d;
            resp1_q      <= resp1_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_pend_d    = aw_pend_q;
        w_pend_d     = w_pend_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        resp0_d      = resp0_q;
        resp1_d      = resp1_q;
        err_cnt_d    = err_cnt_q;
        sel_write    = 1'b0;
        cpl          = 1'b0;
        cpl_resp     = 2'b00;
        cpl_data     = '0;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    if (grant1) begin
                        sel_write = req1_write;
                        addr_d    = req1_addr;
                        wdata_d   = req1_wdata;
                        wstrb_d   = req1_wstrb;
                    end else begin
                        sel_write = req0_write;
                        addr_d    = req0_addr;
                        wdata_d   = req0_wdata;
                        wstrb_d   = req0_wstrb;
                    end
                    if (sel_write) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        state_d   = RD_AR;
                    end
                end
            end
            // AW and W retire independently; B is only accepted once both are gone.
            WR_AW_W: begin
                aw_pend_d = aw_pend_q && !M_AXI_AWREADY;
                w_pend_d  = w_pend_q && !M_AXI_WREADY;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                if (M_AXI_BVALID) begin
                    cpl      = 1'b1;
                    cpl_resp = M_AXI_BRESP;
                    state_d  = IDLE;
                end
            end
            RD_AR: begin
                if (M_AXI_ARREADY) begin
                    state_d = RD_R;
                end
            end
            RD_R: begin
                if (M_AXI_RVALID) begin
                    cpl      = 1'b1;
                    cpl_resp = M_AXI_RRESP;
                    cpl_data = M_AXI_RDATA;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cpl) begin
            if (owner_q) begin
                done1_d  = 1'b1;
                rdata1_d = cpl_data;
                resp1_d  = cpl_resp;
            end else begin
                done0_d  = 1'b1;
                rdata0_d = cpl_data;
                resp0_d  = cpl_resp;
            end
            if ((cpl_resp != 2'b00) && (err_cnt_q != ERR_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

endmodule
